// File: rtl/button_monitor_n_bit_pkg.sv
// Shared constants for the push-button monitor.
// Keys are active-low, so the idle/released level is 1.
package button_monitor_n_bit_pkg;

  localparam logic KEY_RELEASED = 1'b1;
  localparam logic KEY_PRESSED  = 1'b0;

  function automatic logic press_edge(
    input logic prev_lvl,
    input logic cur_lvl
  );
    return (prev_lvl == KEY_RELEASED) &&
           (cur_lvl == KEY_PRESSED);
  endfunction

endpackage

// File: rtl/button_monitor.sv
// Single-bit key synchroniser and press (1->0) edge detector.
// Output is decoded from flops only; no path from key.
module button_monitor
  import button_monitor_n_bit_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic key,
  output logic keyEdge
);

  (* ASYNC_REG = "TRUE" *) logic sync1;
  (* ASYNC_REG = "TRUE" *) logic sync2;
  logic prev;

  // Reset forgets history: every key looks released.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= KEY_RELEASED;
      sync2 <= KEY_RELEASED;
      prev  <= KEY_RELEASED;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign keyEdge = press_edge(prev, sync2);

endmodule

// File: rtl/button_monitor_n_bit.sv
// N-bit push-button monitor: one independent
// sync + press-strobe channel per key bit.
module button_monitor_n_bit
  import button_monitor_n_bit_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] key,
  output logic [WIDTH-1:0] keyEdge
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    button_monitor u_ch (
      .clock   (clock),
      .reset   (reset),
      .key     (key[i]),
      .keyEdge (keyEdge[i])
    );
  end

endmodule

// File: tb/tb_button_monitor_n_bit.sv
// Scoreboard bench for button_monitor_n_bit: a sampled-history
// reference model predicts each cycle's strobes.
module tb_button_monitor_n_bit;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] key   = '1;
  logic [W-1:0] keyEdge;
  logic         k1    = 1'b1;
  logic         e1;

  int vectors = 0;
  int errors  = 0;
  int p1      = 0;

  always #5 clock = ~clock;

  button_monitor_n_bit #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset   (reset),
    .key     (key),
    .keyEdge (keyEdge)
  );

  button_monitor_n_bit #(.WIDTH(1)) dut1 (
    .clock   (clock),
    .reset   (reset),
    .key     (k1),
    .keyEdge (e1)
  );

  // Reference: a press is "released two samples ago, pressed
  // one sample ago"; a reset sample counts as released and
  // the strobe is forced low on any reset edge.
  logic [W-1:0] h_new = '1;
  logic [W-1:0] h_old = '1;
  logic [W-1:0] expq[$];

  always @(posedge clock) begin
    logic [W-1:0] s;
    logic [W-1:0] e;
    s = reset ? '1 : key;
    e = reset ? '0 : (h_old & ~h_new);
    h_old = h_new;
    h_new = s;
    expq.push_back(e);
  end

  always @(posedge clock) begin
    logic [W-1:0] ex;
    #1;
    vectors++;
    if (expq.size() == 0) begin
      errors++;
      $display("FAIL sb_empty t=%0t keyEdge=%b", $time, keyEdge);
    end else begin
      ex = expq.pop_front();
      if (keyEdge !== ex) begin
        errors++;
        $display("FAIL keyEdge t=%0t got=%b exp=%b key=%b",
                 $time, keyEdge, ex, key);
      end
    end
    if (e1 === 1'b1) p1++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk1(input string nm, input int got,
                      input int lo, input int hi);
    vectors++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d..%0d", nm, got, lo, hi);
    end
  endtask

  initial begin
    int p0;
    @(negedge clock);
    reset = 1'b1; key = '1;
    cyc(2);
    reset = 1'b0;
    cyc(3);
    key = 4'b1110; cyc(4);
    key = 4'b1111; cyc(4);
    for (int i = 0; i < W; i++) begin
      key = ~(4'b0001 << i);
      cyc(4);
    end
    key = 4'b1111; cyc(4);
    key = 4'b0000; cyc(4);
    key = 4'b1111; cyc(4);
    reset = 1'b1; key = 4'b1011; cyc(2);
    reset = 1'b0; cyc(4);
    key = 4'b1111; cyc(3);
    key = 4'b0111; cyc(2);
    reset = 1'b1; cyc(1);
    reset = 1'b0; cyc(3);
    key = 4'b1111; cyc(3);
    for (int n = 0; n < 300; n++) begin
      key   = W'($urandom);
      reset = ($urandom_range(0, 29) == 0);
      cyc($urandom_range(1, 4));
    end
    reset = 1'b0; key = '1; k1 = 1'b1;
    cyc(4);
    p0 = p1;
    k1 = 1'b0; cyc(1);
    k1 = 1'b1; cyc(5);
    chk1("w1_glitch", p1 - p0, 0, 1);
    p0 = p1;
    k1 = 1'b0; cyc(2);
    k1 = 1'b1; cyc(5);
    chk1("w1_two_cycle", p1 - p0, 1, 1);
    p0 = p1;
    k1 = 1'b0; cyc(6);
    chk1("w1_held", p1 - p0, 1, 1);
    k1 = 1'b1; cyc(5);
    chk1("w1_release", p1 - p0, 1, 1);
    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1);
  end

endmodule
